adb_ps2_scancode: RTL

- Translates ADB key events (keycode plus up/down flag) into PS/2 Scan Code Set 2 byte sequences.
- Produces make codes, break codes and E0-extended codes, plus single-key typematic repeat.
- Sits between the ADB receiver and the PS/2 serializer. Its byte-stream output connects directly to the serializer's tdata/tvalid/tready input.

---
 rtl/adb_ps2_scancode_pkg.sv | 141 ++++++++++++++
 rtl/adb_ps2_scancode_if.sv | 19 +
 rtl/adb_ps2_scancode_typematic.sv | 43 ++++
 rtl/adb_ps2_scancode.sv | 139 +++++++++++++
 4 files changed

// File: rtl/adb_ps2_scancode_pkg.sv
// rtl/adb_ps2_scancode_pkg.sv - shared types, constants and ADB-to-Set-2 table
package adb_ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  typedef struct packed {
    logic       mapped;
    logic       ext;
    logic [7:0] code;
  } scan_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SEND_E0,
    SEND_F0,
    SEND_CODE
  } state_t;

  function automatic scan_entry_t plain_key(input logic [7:0] code);
    return '{mapped: 1'b1, ext: 1'b0, code: code};
  endfunction

  function automatic scan_entry_t ext_key(input logic [7:0] code);
    return '{mapped: 1'b1, ext: 1'b1, code: code};
  endfunction

  // Keys with multi-prefix Set 2 sequences (Print Screen, Pause) and Fn/Power stay unmapped.
  function automatic scan_entry_t adb_to_set2(input logic [6:0] key);
    scan_entry_t e;
    e = '{mapped: 1'b0, ext: 1'b0, code: 8'h00};
    case (key)
      7'h00: e = plain_key(8'h1C);
      7'h01: e = plain_key(8'h1B);
      7'h02: e = plain_key(8'h23);
      7'h03: e = plain_key(8'h2B);
      7'h04: e = plain_key(8'h33);
      7'h05: e = plain_key(8'h34);
      7'h06: e = plain_key(8'h1A);
      7'h07: e = plain_key(8'h22);
      7'h08: e = plain_key(8'h21);
      7'h09: e = plain_key(8'h2A);
      7'h0A: e = plain_key(8'h61);
      7'h0B: e = plain_key(8'h32);
      7'h0C: e = plain_key(8'h15);
      7'h0D: e = plain_key(8'h1D);
      7'h0E: e = plain_key(8'h24);
      7'h0F: e = plain_key(8'h2D);
      7'h10: e = plain_key(8'h35);
      7'h11: e = plain_key(8'h2C);
      7'h12: e = plain_key(8'h16);
      7'h13: e = plain_key(8'h1E);
      7'h14: e = plain_key(8'h26);
      7'h15: e = plain_key(8'h25);
      7'h16: e = plain_key(8'h36);
      7'h17: e = plain_key(8'h2E);
      7'h18: e = plain_key(8'h55);
      7'h19: e = plain_key(8'h46);
      7'h1A: e = plain_key(8'h3D);
      7'h1B: e = plain_key(8'h4E);
      7'h1C: e = plain_key(8'h3E);
      7'h1D: e = plain_key(8'h45);
      7'h1E: e = plain_key(8'h5B);
      7'h1F: e = plain_key(8'h44);
      7'h20: e = plain_key(8'h3C);
      7'h21: e = plain_key(8'h54);
      7'h22: e = plain_key(8'h43);
      7'h23: e = plain_key(8'h4D);
      7'h24: e = plain_key(8'h5A);
      7'h25: e = plain_key(8'h4B);
      7'h26: e = plain_key(8'h3B);
      7'h27: e = plain_key(8'h52);
      7'h28: e = plain_key(8'h42);
      7'h29: e = plain_key(8'h4C);
      7'h2A: e = plain_key(8'h5D);
      7'h2B: e = plain_key(8'h41);
      7'h2C: e = plain_key(8'h4A);
      7'h2D: e = plain_key(8'h31);
      7'h2E: e = plain_key(8'h3A);
      7'h2F: e = plain_key(8'h49);
      7'h30: e = plain_key(8'h0D);
      7'h31: e = plain_key(8'h29);
      7'h32: e = plain_key(8'h0E);
      7'h33: e = plain_key(8'h66);
      7'h35: e = plain_key(8'h76);
      7'h36: e = plain_key(8'h14);
      7'h37: e = ext_key(8'h1F);
      7'h38: e = plain_key(8'h12);
      7'h39: e = plain_key(8'h58);
      7'h3A: e = plain_key(8'h11);
      7'h3B: e = ext_key(8'h6B);
      7'h3C: e = ext_key(8'h74);
      7'h3D: e = ext_key(8'h72);
      7'h3E: e = ext_key(8'h75);
      7'h41: e = plain_key(8'h71);
      7'h43: e = plain_key(8'h7C);
      7'h45: e = plain_key(8'h79);
      7'h47: e = plain_key(8'h77);
      7'h4B: e = ext_key(8'h4A);
      7'h4C: e = ext_key(8'h5A);
      7'h4E: e = plain_key(8'h7B);
      7'h51: e = plain_key(8'h0F);
      7'h52: e = plain_key(8'h70);
      7'h53: e = plain_key(8'h69);
      7'h54: e = plain_key(8'h72);
      7'h55: e = plain_key(8'h7A);
      7'h56: e = plain_key(8'h6B);
      7'h57: e = plain_key(8'h73);
      7'h58: e = plain_key(8'h74);
      7'h59: e = plain_key(8'h6C);
      7'h5B: e = plain_key(8'h75);
      7'h5C: e = plain_key(8'h7D);
      7'h60: e = plain_key(8'h03);
      7'h61: e = plain_key(8'h0B);
      7'h62: e = plain_key(8'h83);
      7'h63: e = plain_key(8'h04);
      7'h64: e = plain_key(8'h0A);
      7'h65: e = plain_key(8'h01);
      7'h67: e = plain_key(8'h78);
      7'h6B: e = plain_key(8'h7E);
      7'h6D: e = plain_key(8'h09);
      7'h6F: e = plain_key(8'h07);
      7'h72: e = ext_key(8'h70);
      7'h73: e = ext_key(8'h6C);
      7'h74: e = ext_key(8'h7D);
      7'h75: e = ext_key(8'h71);
      7'h76: e = plain_key(8'h0C);
      7'h77: e = ext_key(8'h69);
      7'h78: e = plain_key(8'h06);
      7'h79: e = ext_key(8'h7A);
      7'h7A: e = plain_key(8'h05);
      7'h7B: e = plain_key(8'h59);
      7'h7C: e = ext_key(8'h11);
      7'h7D: e = ext_key(8'h14);
      default: e = '{mapped: 1'b0, ext: 1'b0, code: 8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/adb_ps2_scancode_if.sv
// rtl/adb_ps2_scancode_if.sv - ADB event input and PS/2 byte output streams
interface adb_ps2_scancode_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/adb_ps2_scancode_typematic.sv
// rtl/adb_ps2_scancode_typematic.sv - held-key tracking and typematic repeat timer
module adb_ps2_typematic #(
  parameter int DELAY_CYCLES = 500000,
  parameter int RATE_CYCLES  = 92000,
  parameter int CNT_W        = $clog2(DELAY_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       make_ev,
  input  logic       break_ev,
  input  logic [6:0] ev_key,
  input  logic       repeat_taken,
  output logic       repeat_due,
  output logic [6:0] held_key
);

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(RATE_CYCLES);

  logic             armed;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      cnt      <= '0;
      held_key <= '0;
    end else if (make_ev) begin
      armed    <= 1'b1;
      held_key <= ev_key;
      cnt      <= DELAY_LD;
    end else if (break_ev && ev_key == held_key) begin
      armed <= 1'b0;
    end else if (repeat_taken) begin
      cnt <= RATE_LD;
    end else if (armed && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign repeat_due = armed && (cnt == '0);

endmodule

// File: rtl/adb_ps2_scancode.sv
// rtl/adb_ps2_scancode.sv - ADB key events to PS/2 Set 2 make/break byte stream
module adb_ps2_scancode
  import adb_ps2_pkg::*;
#(
  parameter int DELAY_CYCLES = 500000,
  parameter int RATE_CYCLES  = 92000,
  parameter int CNT_W        = $clog2(DELAY_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adb_ps2_scancode_if.slave         bus,
  output logic [7:0]                drop_count
);

  state_t      state_q, state_d;
  logic        run_q;
  logic [6:0]  ev_key_q;
  logic        ev_rel_q;
  logic        ev_rep_q;
  scan_entry_t entry_q;
  logic        rom_vld_q;

  logic        s_tready;
  logic        s_fire;
  logic        repeat_due;
  logic        repeat_taken;
  logic [6:0]  held_key;
  logic        make_ev;
  logic        break_ev;
  logic        drop_inc;
  logic        m_tvalid;
  logic [7:0]  m_tdata;

  assign s_tready     = run_q && (state_q == IDLE);
  assign s_fire       = bus.s_tvalid && s_tready;
  // A repeat arriving alongside a new event is consumed (timer reloaded) but not emitted.
  assign repeat_taken = run_q && (state_q == IDLE) && repeat_due;

  assign bus.s_tready = s_tready;
  assign bus.m_tvalid = m_tvalid;
  assign bus.m_tdata  = m_tdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      ev_key_q   <= '0;
      ev_rel_q   <= 1'b0;
      ev_rep_q   <= 1'b0;
      entry_q    <= '0;
      rom_vld_q  <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      entry_q   <= adb_to_set2(ev_key_q);
      rom_vld_q <= (state_q == LOOKUP) && !rom_vld_q;
      if (s_fire) begin
        ev_key_q <= bus.s_tdata[6:0];
        ev_rel_q <= bus.s_tdata[7];
        ev_rep_q <= 1'b0;
      end else if (repeat_taken) begin
        ev_key_q <= held_key;
        ev_rel_q <= 1'b0;
        ev_rep_q <= 1'b1;
      end
      if (drop_inc && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    make_ev  = 1'b0;
    break_ev = 1'b0;
    drop_inc = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    case (state_q)
      IDLE: begin
        if (s_fire || repeat_taken)
          state_d = LOOKUP;
      end
      LOOKUP: begin
        // The table output is registered, so the first LOOKUP cycle only waits for it.
        if (rom_vld_q) begin
          if (!entry_q.mapped) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else begin
            make_ev  = !ev_rel_q && !ev_rep_q;
            break_ev = ev_rel_q;
            if (entry_q.ext)
              state_d = SEND_E0;
            else if (ev_rel_q)
              state_d = SEND_F0;
            else
              state_d = SEND_CODE;
          end
        end
      end
      SEND_E0: begin
        m_tvalid = 1'b1;
        m_tdata  = PS2_EXT;
        if (bus.m_tready)
          state_d = ev_rel_q ? SEND_F0 : SEND_CODE;
      end
      SEND_F0: begin
        m_tvalid = 1'b1;
        m_tdata  = PS2_BREAK;
        if (bus.m_tready)
          state_d = SEND_CODE;
      end
      SEND_CODE: begin
        m_tvalid = 1'b1;
        m_tdata  = entry_q.code;
        if (bus.m_tready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  adb_ps2_typematic #(
    .DELAY_CYCLES (DELAY_CYCLES),
    .RATE_CYCLES  (RATE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_typematic (
    .clk          (clk),
    .rst_n        (rst_n),
    .make_ev      (make_ev),
    .break_ev     (break_ev),
    .ev_key       (ev_key_q),
    .repeat_taken (repeat_taken),
    .repeat_due   (repeat_due),
    .held_key     (held_key)
  );

endmodule
